// File: rtl/keypad_scanner_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
// Codes are 4*row_index + col_index throughout.
package keypad_scanner_pkg;

    typedef enum logic [1:0] {
        KEY_NONE   = 2'd0,
        KEY_SINGLE = 2'd1,
        KEY_MULTI  = 2'd2
    } sweep_kind_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAND    = 2'd1,
        PRESSED = 2'd2
    } deb_state_e;

    // ASCII legend printed on each key, looked up by the display side (seg7_control).
    localparam logic [7:0] KEY_LABEL [16] = '{
        "1", "2", "3", "A",
        "4", "5", "6", "B",
        "7", "8", "9", "C",
        "*", "0", "#", "D"
    };

    function automatic logic [7:0] key_label(input logic [3:0] code);
        return KEY_LABEL[code];
    endfunction

    // Number of set bits, saturated at 2 (2 means "two or more").
    function automatic logic [1:0] hit_count(input logic [3:0] hits);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, hits[i]};
        end
        return (n >= 3'd2) ? 2'd2 : n[1:0];
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] hits);
        logic [1:0] idx;
        idx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (hits[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// Column strobe rotation, row synchroniser and per-sweep hit accumulator.
// Emits sweep_done_o on the cycle column 3 is sampled, with the sweep's result.
module keypad_col_scan
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic [3:0]  row_i,
    output logic [3:0]  col_o,
    output logic        sweep_done_o,
    output sweep_kind_e sweep_kind_o,
    output logic [3:0]  sweep_code_o
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    logic [3:0]    row_meta_q, row_sync_q;
    logic [DW-1:0] dwell_q;
    logic [1:0]    col_idx_q;
    logic [3:0]    col_q;
    logic [1:0]    acc_cnt_q, acc_cnt_d;
    logic [3:0]    acc_code_q, acc_code_d;

    logic       sample;
    logic [3:0] hits;
    logic [1:0] col_cnt;
    logic [2:0] sum;

    assign sample  = (dwell_q == DWELL_LAST);
    assign hits    = ~row_sync_q;
    assign col_cnt = hit_count(hits);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sum        = {1'b0, acc_cnt_q} + {1'b0, col_cnt};
        acc_cnt_d  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        acc_code_d = acc_code_q;
        if (col_cnt != 2'd0) acc_code_d = {low_index(hits), col_idx_q};
    end

    assign sweep_done_o = sample && (col_idx_q == 2'd3);
    assign sweep_code_o = acc_code_d;
    assign sweep_kind_o = (acc_cnt_d == 2'd0) ? KEY_NONE :
                          (acc_cnt_d == 2'd1) ? KEY_SINGLE : KEY_MULTI;
    assign col_o        = col_q;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            dwell_q    <= '0;
            col_idx_q  <= '0;
            col_q      <= 4'b1110;
            acc_cnt_q  <= '0;
            acc_code_q <= '0;
        end else begin
            row_meta_q <= row_i;
            row_sync_q <= row_meta_q;
            if (sample) begin
                dwell_q   <= '0;
                col_idx_q <= col_idx_q + 2'd1;
                col_q     <= {col_q[2:0], col_q[3]};
                if (col_idx_q == 2'd3) begin
                    acc_cnt_q  <= '0;
                    acc_code_q <= '0;
                end else begin
                    acc_cnt_q  <= acc_cnt_d;
                    acc_code_q <= acc_code_d;
                end
            end else begin
                dwell_q <= dwell_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad reader: column scan plus sweep-level debounce FSM.
// A key is accepted after DEBOUNCE_SWEEPS identical single-key sweeps and released after as many empty ones.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 100000,
    parameter int unsigned DEBOUNCE_SWEEPS = 5
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CW = $clog2(DEBOUNCE_SWEEPS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SWEEPS - 1);

    logic        sweep_done;
    sweep_kind_e sweep_kind;
    logic [3:0]  sweep_code;

    deb_state_e  state_q;
    logic [3:0]  cand_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]  key_code_q;
    logic        key_valid_q;
    logic        key_held_q;

    keypad_col_scan #(
        .SCAN_DIV(SCAN_DIV)
    ) u_col_scan (
        .clk_100MHz  (clk_100MHz),
        .reset       (reset),
        .row_i       (row),
        .col_o       (col),
        .sweep_done_o(sweep_done),
        .sweep_kind_o(sweep_kind),
        .sweep_code_o(sweep_code)
    );

    // cnt_q counts consistent press sweeps in CAND and empty sweeps in PRESSED.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (sweep_done) begin
                case (state_q)
                    IDLE: begin
                        if (sweep_kind == KEY_SINGLE) begin
                            cand_q <= sweep_code;
                            if (DEBOUNCE_SWEEPS == 1) begin
                                state_q     <= PRESSED;
                                key_code_q  <= sweep_code;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                                cnt_q       <= '0;
                            end else begin
                                state_q <= CAND;
                                cnt_q   <= CW'(1);
                            end
                        end
                    end
                    CAND: begin
                        if (sweep_kind == KEY_SINGLE) begin
                            if (sweep_code == cand_q) begin
                                if (cnt_q == CNT_LAST) begin
                                    state_q     <= PRESSED;
                                    key_code_q  <= cand_q;
                                    key_valid_q <= 1'b1;
                                    key_held_q  <= 1'b1;
                                    cnt_q       <= '0;
                                end else begin
                                    cnt_q <= cnt_q + 1'b1;
                                end
                            end else begin
                                cand_q <= sweep_code;
                                cnt_q  <= CW'(1);
                            end
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end
                    end
                    PRESSED: begin
                        if (sweep_kind == KEY_NONE) begin
                            if (cnt_q == CNT_LAST) begin
                                state_q    <= IDLE;
                                key_held_q <= 1'b0;
                                cnt_q      <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: stimulus queues expected key events, a monitor checks them.
// Key presses are modelled as row/column shorts driven from the live column strobes.
module tb_keypad_scanner;

    localparam int SD    = 4;
    localparam int DS    = 3;
    localparam int SWEEP = 4 * SD;

    logic       clk_100MHz = 1'b0;
    logic       reset;
    logic [3:0] row, col, key_code;
    logic       key_valid, key_held;

    logic [15:0] keys = '0;
    int          cyc;
    int          n_checks = 0;
    int          n_fail   = 0;

    typedef struct {
        logic [3:0] code;
        int         at;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk_100MHz = ~clk_100MHz;

    keypad_scanner #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SWEEPS(DS)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // A pressed key at (r,c) pulls row[r] low only while col[c] is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[4*r+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    always @(posedge clk_100MHz or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: column rotation every cycle, and every key_valid against the scoreboard.
    exp_t       mon_e;
    logic [3:0] mon_col;
    always @(negedge clk_100MHz) begin
        if (reset === 1'b0) begin
            mon_col = ~(4'b0001 << ((cyc / SD) % 4));
            check("col", 32'(col), 32'(mon_col));
            if (key_valid !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected key_valid", 32'(key_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("key_code", 32'(key_code), 32'(mon_e.code));
                    check("key_valid cycle", 32'(cyc), 32'(mon_e.at));
                    check("key_held with key_valid", 32'(key_held), 32'd1);
                end
            end
        end
    end

    task automatic sweeps(input int n);
        repeat (n * SWEEP) @(negedge clk_100MHz);
    endtask

    // Called on a sweep boundary when the key set that will be accepted first appears.
    task automatic expect_key(input logic [3:0] code);
        exp_t e;
        e.code = code;
        e.at   = cyc + DS * SWEEP;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1;
        #1;
        check("reset col", 32'(col), 32'hE);
        check("reset key_code", 32'(key_code), 32'd0);
        check("reset key_valid", 32'(key_valid), 32'd0);
        check("reset key_held", 32'(key_held), 32'd0);
        repeat (3) @(negedge clk_100MHz);
        reset = 1'b0;

        // Idle: ten empty sweeps.
        sweeps(10);
        check("idle key_held", 32'(key_held), 32'd0);

        // Clean press of key 9 (row 2, col 1), held 5 sweeps then released.
        keys = 16'(1) << 9;
        expect_key(4'd9);
        sweeps(5);
        check("press9 key_held", 32'(key_held), 32'd1);
        keys = '0;
        sweeps(2);
        check("release9 held after 2 empty", 32'(key_held), 32'd1);
        sweeps(1);
        check("release9 held after 3 empty", 32'(key_held), 32'd0);
        check("release9 key_code kept", 32'(key_code), 32'd9);

        // Bounce on key 0, then steady.
        for (int i = 0; i < 6; i++) begin
            keys = (i % 2 == 0) ? 16'h0001 : 16'h0000;
            sweeps(1);
        end
        check("bounce no held", 32'(key_held), 32'd0);
        keys = 16'h0001;
        expect_key(4'd0);
        sweeps(4);
        check("key0 key_held", 32'(key_held), 32'd1);
        keys = '0;
        sweeps(3);
        check("key0 released", 32'(key_held), 32'd0);

        // Key 5 for two sweeps, then key 6.
        keys = 16'(1) << 5;
        sweeps(2);
        keys = 16'(1) << 6;
        expect_key(4'd6);
        sweeps(4);
        check("key6 key_held", 32'(key_held), 32'd1);
        keys = '0;
        sweeps(3);
        check("key6 released", 32'(key_held), 32'd0);

        // Simultaneous 3+12 from idle is rejected.
        keys = (16'(1) << 3) | (16'(1) << 12);
        sweeps(4);
        check("multi no held", 32'(key_held), 32'd0);
        keys = '0;
        sweeps(1);

        // Key 3, then 12 added (rollover), then 12 alone, then full release.
        keys = 16'(1) << 3;
        expect_key(4'd3);
        sweeps(4);
        check("key3 key_held", 32'(key_held), 32'd1);
        keys = (16'(1) << 3) | (16'(1) << 12);
        sweeps(4);
        check("rollover key_held", 32'(key_held), 32'd1);
        keys = 16'(1) << 12;
        sweeps(2);
        check("key12 alone still held", 32'(key_held), 32'd1);
        keys = '0;
        sweeps(2);
        check("rollover held after 2 empty", 32'(key_held), 32'd1);
        sweeps(1);
        check("rollover held after 3 empty", 32'(key_held), 32'd0);
        check("rollover key_code", 32'(key_code), 32'd3);

        // Reset during the second candidate sweep of key 7.
        keys = 16'(1) << 7;
        sweeps(1);
        repeat (SWEEP / 2) @(negedge clk_100MHz);
        reset = 1'b1;
        #1;
        check("midreset col", 32'(col), 32'hE);
        check("midreset key_code", 32'(key_code), 32'd0);
        check("midreset key_valid", 32'(key_valid), 32'd0);
        check("midreset key_held", 32'(key_held), 32'd0);
        repeat (3) @(negedge clk_100MHz);
        reset = 1'b0;
        expect_key(4'd7);
        sweeps(4);
        check("key7 key_held", 32'(key_held), 32'd1);
        keys = '0;
        sweeps(3);
        check("key7 released", 32'(key_held), 32'd0);
        check("key7 key_code kept", 32'(key_code), 32'd7);

        check("pending expected keys", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
